// File: rtl/alu_reg.sv
// Registered 3-bit-opcode integer ALU: AND/OR/ADD/SUB/SLT plus inverted-B variants.
// A single shared adder serves ADD, SUB and both signed set-less-than forms.
module alu_reg #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       alucont,
   output logic [WIDTH-1:0] result,
   output logic             zero
);

   localparam int unsigned MSB = WIDTH - 1;

   logic [WIDTH-1:0] w_bb;
   logic [WIDTH-1:0] w_sum;
   logic             w_ovf;
   logic             w_slt;
   logic [WIDTH-1:0] w_next_result;

   // Overflow-corrected sign makes SLT a true signed compare even across the wrap.
   always_comb begin
      w_bb          = alucont[2] ? ~b : b;
      w_sum         = a + w_bb + WIDTH'(alucont[2]);
      w_ovf         = (a[MSB] == w_bb[MSB]) && (w_sum[MSB] != a[MSB]);
      w_slt         = w_sum[MSB] ^ w_ovf;
      w_next_result = '0;
      case (alucont[1:0])
         2'b00:   w_next_result = a & w_bb;
         2'b01:   w_next_result = a | w_bb;
         2'b10:   w_next_result = w_sum;
         default: w_next_result = WIDTH'(w_slt);
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         result <= '0;
         zero   <= 1'b1;
      end else begin
         result <= w_next_result;
         zero   <= (w_next_result == '0);
      end
   end

endmodule

// File: tb/tb_alu_reg.sv
// Directed and random checks for alu_reg with WIDTH=32.
module tb_alu_reg;

   logic        clk;
   logic        reset;
   logic [31:0] a;
   logic [31:0] b;
   logic [2:0]  alucont;
   logic [31:0] result;
   logic        zero;

   int unsigned n_pass;
   int unsigned n_total;

   alu_reg #(.WIDTH(32)) dut (
      .clk     (clk),
      .reset   (reset),
      .a       (a),
      .b       (b),
      .alucont (alucont),
      .result  (result),
      .zero    (zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Independent reference: wide signed arithmetic instead of the overflow trick.
   function automatic logic [31:0] model(input logic [31:0] ma, input logic [31:0] mb,
                                         input logic [2:0] op);
      logic signed [32:0] s;
      case (op)
         3'd0: model = ma & mb;
         3'd1: model = ma | mb;
         3'd2: model = ma + mb;
         3'd3: begin
            s     = $signed({ma[31], ma}) + $signed({mb[31], mb});
            model = {31'd0, s[32]};
         end
         3'd4: model = ma & ~mb;
         3'd5: model = ma | ~mb;
         3'd6: model = ma - mb;
         default: model = ($signed(ma) < $signed(mb)) ? 32'd1 : 32'd0;
      endcase
   endfunction

   task automatic drive(input logic [31:0] va, input logic [31:0] vb, input logic [2:0] op);
      @(negedge clk);
      a       = va;
      b       = vb;
      alucont = op;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      a = 32'd123; b = 32'd456; alucont = 3'd2;
      repeat (2) @(posedge clk);
      #1;
      n_total++;
      if (result !== 32'd0 || zero !== 1'b1)
         $display("FAIL reset_init: result=%0d zero=%0b, want 0/1", result, zero);
      else n_pass++;
      @(negedge clk);
      reset = 1'b0;
      drive(32'd100, 32'd50, 3'd2);
      n_total++;
      if (result !== 32'd150 || zero !== 1'b0)
         $display("FAIL reset_first_op: result=%0d zero=%0b, want 150/0", result, zero);
      else n_pass++;
      // Async assertion between edges must clear the outputs immediately.
      #2 reset = 1'b1;
      #1;
      n_total++;
      if (result !== 32'd0 || zero !== 1'b1)
         $display("FAIL reset_async: result=%0d zero=%0b, want 0/1", result, zero);
      else n_pass++;
      @(posedge clk);
      #1;
      n_total++;
      if (result !== 32'd0 || zero !== 1'b1)
         $display("FAIL reset_hold: result=%0d zero=%0b, want 0/1", result, zero);
      else n_pass++;
      @(negedge clk);
      reset = 1'b0;
      drive(32'd100, 32'd50, 3'd2);
      n_total++;
      if (result !== 32'd150 || zero !== 1'b0)
         $display("FAIL reset_release: result=%0d zero=%0b, want 150/0", result, zero);
      else n_pass++;
   endtask

   task automatic test_sweep(input logic [31:0] va, input logic [31:0] vb,
                             input logic [31:0] e0, input logic [31:0] e1,
                             input logic [31:0] e2, input logic [31:0] e3,
                             input logic [31:0] e4, input logic [31:0] e5,
                             input logic [31:0] e6, input logic [31:0] e7);
      logic [31:0] exp_r [8];
      exp_r = '{e0, e1, e2, e3, e4, e5, e6, e7};
      for (int i = 0; i < 8; i++) begin
         drive(va, vb, 3'(i));
         n_total++;
         if (result !== exp_r[i] || zero !== (exp_r[i] == 32'd0))
            $display("FAIL sweep a=%0d b=%0d op=%0d: result=%0d zero=%0b, want %0d/%0b",
                     va, vb, i, result, zero, exp_r[i], exp_r[i] == 32'd0);
         else n_pass++;
      end
   endtask

   task automatic test_slt_edges;
      logic [31:0] va [4];
      logic [31:0] vb [4];
      logic [31:0] ex [4];
      va = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'd5};
      vb = '{32'd1,         32'h7FFF_FFFF, 32'h8000_0000, 32'd5};
      ex = '{32'd1,         32'd1,         32'd0,         32'd0};
      for (int i = 0; i < 4; i++) begin
         drive(va[i], vb[i], 3'b111);
         n_total++;
         if (result !== ex[i])
            $display("FAIL slt_edge %0d: result=%0d, want %0d", i, result, ex[i]);
         else n_pass++;
      end
      drive(32'h8000_0000, 32'd1, 3'b111);
      n_total++;
      if (result !== 32'd1)
         $display("FAIL slt_min_vs_1: result=%0d, want 1", result);
      else n_pass++;
   endtask

   task automatic test_wrap_zero;
      logic [31:0] va [3];
      logic [31:0] vb [3];
      logic [2:0]  op [3];
      logic [31:0] ex [3];
      logic        ez [3];
      va = '{32'hFFFF_FFFF, 32'd7, 32'd0};
      vb = '{32'd1,         32'd7, 32'd1};
      op = '{3'b010,        3'b110, 3'b110};
      ex = '{32'd0,         32'd0, 32'hFFFF_FFFF};
      ez = '{1'b1,          1'b1,  1'b0};
      for (int i = 0; i < 3; i++) begin
         drive(va[i], vb[i], op[i]);
         n_total++;
         if (result !== ex[i] || zero !== ez[i])
            $display("FAIL wrap_zero %0d: result=%h zero=%0b, want %h/%0b",
                     i, result, zero, ex[i], ez[i]);
         else n_pass++;
      end
   endtask

   task automatic test_back_to_back;
      logic [31:0] ra;
      logic [31:0] rb;
      logic [2:0]  rop;
      logic [31:0] ex;
      for (int i = 0; i < 20; i++) begin
         ra  = $urandom;
         rb  = (i % 4 == 0) ? ra : $urandom;
         rop = 3'($urandom_range(0, 7));
         drive(ra, rb, rop);
         ex = model(ra, rb, rop);
         n_total++;
         if (result !== ex || zero !== (ex == 32'd0))
            $display("FAIL b2b %0d a=%h b=%h op=%0d: result=%h zero=%0b, want %h/%0b",
                     i, ra, rb, rop, result, zero, ex, ex == 32'd0);
         else n_pass++;
      end
   endtask

   initial begin
      n_pass  = 0;
      n_total = 0;
      test_reset();
      test_sweep(32'd200, 32'd300, 32'd8, 32'd492, 32'd500, 32'd0,
                 32'd192, 32'd4294967003, 32'd4294967196, 32'd1);
      test_sweep(32'd100, 32'd50, 32'd32, 32'd118, 32'd150, 32'd0,
                 32'd68, 32'd4294967277, 32'd50, 32'd0);
      test_slt_edges();
      test_wrap_zero();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
